// File: rtl/vend_pkg.sv
// Shared types and constants for the parameterised vending machine:
// FSM state encoding, coin values, change denomination and audit counter width.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } vend_state_e;

  localparam int unsigned COIN_QUARTER = 25;
  localparam int unsigned COIN_DOLLAR  = 100;
  localparam int unsigned CHANGE_COIN  = 25;
  localparam int unsigned SALES_W      = 16;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: flags a 0->1 transition of sig_i against the value
// sampled on the previous clock. History is cleared by synchronous reset.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/vend_machine_param.sv
// Parameterised vending machine: coin credit, one-hot product vend, stock
// tracking with restock, and quarter-by-quarter change. Optional per-product
// sales audit counters are built only when VEND_AUDIT_EN is defined.
module vend_machine_param
  import vend_pkg::*;
#(
  parameter int unsigned                    N_PROD     = 4,
  parameter int unsigned                    STOCK_W    = 4,
  parameter int unsigned                    MONEY_W    = 12,
  parameter int unsigned                    MAX_CREDIT = 995,
  parameter logic [N_PROD*MONEY_W-1:0]      PRICES     = {12'd200, 12'd150, 12'd75, 12'd25}
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        quarter,
  input  logic                        dollar,
  input  logic [N_PROD-1:0]           select,
  input  logic                        buy,
  input  logic                        refund,
  input  logic [N_PROD-1:0]           load,
  output logic [MONEY_W-1:0]          money,
  output logic [N_PROD-1:0]           products,
  output logic [N_PROD-1:0]           out_of_stock,
  output logic                        refundLED,
  output logic                        coin_out,
  output logic                        coin_reject,
  output logic                        busy,
  output logic [N_PROD*SALES_W-1:0]   sales_count
);

  localparam logic [STOCK_W-1:0] STOCK_FULL  = '1;
  localparam logic [MONEY_W:0]   MAX_EXT     = (MONEY_W+1)'(MAX_CREDIT);
  localparam logic [MONEY_W:0]   QUARTER_EXT = (MONEY_W+1)'(COIN_QUARTER);
  localparam logic [MONEY_W:0]   DOLLAR_EXT  = (MONEY_W+1)'(COIN_DOLLAR);
  localparam logic [MONEY_W-1:0] CHANGE_AMT  = MONEY_W'(CHANGE_COIN);

  vend_state_e          state_q, state_d;
  logic [MONEY_W-1:0]   money_q, money_d;
  logic                 phase_q, phase_d;
  logic [STOCK_W-1:0]   stock_q [N_PROD];
  logic [STOCK_W-1:0]   stock_d [N_PROD];
  logic [N_PROD-1:0]    products_q, products_d;
  logic [N_PROD-1:0]    oos_q;
  logic                 coin_out_q, coin_out_d;
  logic                 coin_reject_q, coin_reject_d;
  logic                 refund_led_q;

  logic                 quarter_rise, dollar_rise, buy_rise, refund_rise;
  logic [MONEY_W-1:0]   price_a [N_PROD];
  logic [MONEY_W-1:0]   price_sel;
  logic                 stock_ok;
  logic                 sel_onehot;
  logic [MONEY_W:0]     quarter_sum, dollar_sum;

  edge_detect u_edge_quarter (.clk(clk), .rst_n(reset), .sig_i(quarter), .rise_o(quarter_rise));
  edge_detect u_edge_dollar  (.clk(clk), .rst_n(reset), .sig_i(dollar),  .rise_o(dollar_rise));
  edge_detect u_edge_buy     (.clk(clk), .rst_n(reset), .sig_i(buy),     .rise_o(buy_rise));
  edge_detect u_edge_refund  (.clk(clk), .rst_n(reset), .sig_i(refund),  .rise_o(refund_rise));

  for (genvar g = 0; g < N_PROD; g++) begin : g_price
    assign price_a[g] = PRICES[g*MONEY_W +: MONEY_W];
  end

  assign sel_onehot  = (select != '0) && ((select & (select - N_PROD'(1))) == '0);
  assign quarter_sum = {1'b0, money_q} + QUARTER_EXT;
  assign dollar_sum  = {1'b0, money_q} + DOLLAR_EXT;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    price_sel = '0;
    stock_ok  = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (select[i]) begin
        price_sel = price_a[i];
        stock_ok  = (stock_q[i] != '0);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    money_d       = money_q;
    phase_d       = phase_q;
    stock_d       = stock_q;
    products_d    = '0;
    coin_out_d    = 1'b0;
    coin_reject_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Coins outrank refund, which outranks buy; a quarter outranks a dollar.
        if (quarter_rise) begin
          if (quarter_sum <= MAX_EXT) money_d = quarter_sum[MONEY_W-1:0];
          else                        coin_reject_d = 1'b1;
          if (dollar_rise) coin_reject_d = 1'b1;
        end else if (dollar_rise) begin
          if (dollar_sum <= MAX_EXT) money_d = dollar_sum[MONEY_W-1:0];
          else                       coin_reject_d = 1'b1;
        end else if (refund_rise) begin
          if (money_q >= CHANGE_AMT) begin
            state_d = ST_CHANGE;
            phase_d = 1'b0;
          end
        end else if (buy_rise && sel_onehot && stock_ok && (money_q >= price_sel)) begin
          products_d = select;
          money_d    = money_q - price_sel;
          state_d    = ST_VEND;
          for (int i = 0; i < N_PROD; i++) begin
            if (select[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
          end
        end
      end

      ST_VEND: begin
        if (quarter_rise || dollar_rise) coin_reject_d = 1'b1;
        state_d = ST_IDLE;
      end

      ST_CHANGE: begin
        if (quarter_rise || dollar_rise) coin_reject_d = 1'b1;
        if (!phase_q) begin
          // A residue below one change coin is paid as a final coin rather than wrapping.
          coin_out_d = 1'b1;
          money_d    = (money_q > CHANGE_AMT) ? (money_q - CHANGE_AMT) : '0;
          if (money_d == '0) state_d = ST_IDLE;
        end
        phase_d = ~phase_q;
      end

      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < N_PROD; i++) begin
      if (load[i]) stock_d[i] = STOCK_FULL;
    end
  end

  // NOTE: the small stock array is reset to full like any other register; it is not a RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      money_q       <= '0;
      phase_q       <= 1'b0;
      products_q    <= '0;
      oos_q         <= '0;
      coin_out_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      refund_led_q  <= 1'b1;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_FULL;
    end else begin
      state_q       <= state_d;
      money_q       <= money_d;
      phase_q       <= phase_d;
      products_q    <= products_d;
      coin_out_q    <= coin_out_d;
      coin_reject_q <= coin_reject_d;
      refund_led_q  <= (state_d == ST_CHANGE) || coin_out_d;
      stock_q       <= stock_d;
      for (int i = 0; i < N_PROD; i++) oos_q[i] <= (stock_q[i] == '0);
    end
  end

  assign money        = money_q;
  assign products     = products_q;
  assign out_of_stock = oos_q;
  assign refundLED    = refund_led_q;
  assign coin_out     = coin_out_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef VEND_AUDIT_EN
  for (genvar g = 0; g < N_PROD; g++) begin : g_audit
    logic [SALES_W-1:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q <= '0;
      end else if (products_d[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + SALES_W'(1);
      end
    end
    assign sales_count[g*SALES_W +: SALES_W] = cnt_q;
  end
`else
  assign sales_count = '0;
`endif

endmodule

// File: tb/tb_vend_machine_param.sv
// Self-checking bench for vend_machine_param: a table of single-cycle vectors
// plus directed sequences for credit ceiling, change payout, restock and reset.
module tb_vend_machine_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        quarter = 1'b0, dollar = 1'b0, buy = 1'b0, refund = 1'b0;
  logic [3:0]  select = '0, load = '0;
  logic [11:0] money;
  logic [3:0]  products, out_of_stock;
  logic        refundLED, coin_out, coin_reject, busy;
  logic [63:0] sales_count;

  int checks = 0;
  int errors = 0;

  vend_machine_param dut (
    .clk(clk), .reset(reset), .quarter(quarter), .dollar(dollar),
    .select(select), .buy(buy), .refund(refund), .load(load),
    .money(money), .products(products), .out_of_stock(out_of_stock),
    .refundLED(refundLED), .coin_out(coin_out), .coin_reject(coin_reject),
    .busy(busy), .sales_count(sales_count)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  typedef struct {
    logic        q, d, b, r;
    logic [3:0]  sel;
    int          exp_money;
    logic [3:0]  exp_prod;
    logic        exp_rej;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quarter = 0; dollar = 0; buy = 0; refund = 0; select = '0; load = '0;
    reset = 0;
    tick();
    reset = 1;
    tick();
  endtask

  task automatic pulse_quarter();
    quarter = 1; tick(); quarter = 0; tick();
  endtask

  task automatic pulse_dollar();
    dollar = 1; tick(); dollar = 0; tick();
  endtask

  task automatic pulse_buy(input logic [3:0] sel);
    select = sel; buy = 1; tick(); buy = 0; tick();
  endtask

  initial begin
    int pulses;
    int exp_money;

    //             q  d  b  r  sel      money prod     rej busy
    vecs[0]  = '{1, 0, 0, 0, 4'b0000,  25, 4'b0000, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 4'b0000,  25, 4'b0000, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 4'b0000, 125, 4'b0000, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 4'b0000, 125, 4'b0000, 0, 0};
    vecs[4]  = '{1, 1, 0, 0, 4'b0000, 150, 4'b0000, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 4'b0000, 150, 4'b0000, 0, 0};
    vecs[6]  = '{0, 0, 1, 0, 4'b0010,  75, 4'b0010, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 4'b0010,  75, 4'b0000, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 4'b0011,  75, 4'b0000, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 4'b0000,  75, 4'b0000, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 4'b0100,  75, 4'b0000, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 4'b0000,  75, 4'b0000, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 4'b0010, 100, 4'b0000, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 4'b0000, 100, 4'b0000, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 4'b0001,  75, 4'b0001, 0, 1};
    vecs[15] = '{1, 0, 0, 0, 4'b0001,  75, 4'b0000, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 4'b0000,  75, 4'b0000, 0, 0};
    vecs[17] = '{1, 0, 0, 0, 4'b0000, 100, 4'b0000, 0, 0};
    vecs[18] = '{1, 0, 0, 0, 4'b0000, 100, 4'b0000, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 4'b0000, 100, 4'b0000, 0, 0};
    vecs[20] = '{1, 0, 0, 1, 4'b0000, 125, 4'b0000, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 4'b0000, 125, 4'b0000, 0, 0};

    // Reset state
    reset = 0;
    tick();
    check("rst_money", money, 0);
    check("rst_products", products, 0);
    check("rst_oos", out_of_stock, 0);
    check("rst_coin_out", coin_out, 0);
    check("rst_coin_reject", coin_reject, 0);
    check("rst_busy", busy, 0);
    check("rst_refundLED", refundLED, 1);
    check("rst_sales", sales_count, 0);
    reset = 1;
    tick();
    check("rst_release_refundLED", refundLED, 0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 22; i++) begin
      quarter = vecs[i].q; dollar = vecs[i].d; buy = vecs[i].b; refund = vecs[i].r;
      select  = vecs[i].sel;
      tick();
      check($sformatf("vec%0d_money", i), money, 64'(vecs[i].exp_money));
      check($sformatf("vec%0d_products", i), products, vecs[i].exp_prod);
      check($sformatf("vec%0d_coin_reject", i), coin_reject, vecs[i].exp_rej);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
    end
    quarter = 0; dollar = 0; buy = 0; refund = 0; select = '0;

    // Dollar then product 1 (price 75)
    do_reset();
    pulse_dollar();
    select = 4'b0010; buy = 1; tick();
    check("buy1_products", products, 4'b0010);
    check("buy1_money", money, 25);
    check("buy1_stock", dut.stock_q[1], 14);
    buy = 0; tick();
    check("buy1_products_end", products, 0);

    // Credit ceiling
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      dollar = 1; tick();
      check($sformatf("ceil_money_%0d", k), money, 64'(100 * k));
      check($sformatf("ceil_reject_%0d", k), coin_reject, 0);
      dollar = 0; tick();
    end
    dollar = 1; tick();
    check("ceil_reject_10", coin_reject, 1);
    check("ceil_money_10", money, 900);
    dollar = 0; tick();
    check("ceil_reject_end", coin_reject, 0);
    check("ceil_money_end", money, 900);

    // Refund of 100: four coins, every second cycle
    do_reset();
    for (int k = 0; k < 4; k++) pulse_quarter();
    check("chg_start_money", money, 100);
    refund = 1; tick();
    check("chg_enter_led", refundLED, 1);
    check("chg_enter_busy", busy, 1);
    check("chg_enter_money", money, 100);
    refund = 0;
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_money = 100 - 25 * ((k + 1) / 2);
      check($sformatf("chg_coin_%0d", k), coin_out, (k % 2 == 1) ? 1 : 0);
      check($sformatf("chg_money_%0d", k), money, 64'(exp_money));
      check($sformatf("chg_led_%0d", k), refundLED, (k <= 7) ? 1 : 0);
      check($sformatf("chg_busy_%0d", k), busy, (k <= 6) ? 1 : 0);
      if (coin_out) pulses++;
    end
    check("chg_pulse_count", 64'(pulses), 4);

    // Drain product 0, failed buy, restock; then load colliding with a vend
    do_reset();
    for (int k = 0; k < 4; k++) pulse_dollar();
    for (int k = 1; k <= 15; k++) begin
      select = 4'b0001; buy = 1; tick();
      check($sformatf("drain_prod_%0d", k), products, 4'b0001);
      if (k == 15) check("drain_oos_lag", out_of_stock[0], 0);
      buy = 0; tick();
    end
    check("drain_money", money, 25);
    check("drain_oos", out_of_stock[0], 1);
    buy = 1; tick();
    check("empty_buy_prod", products, 0);
    check("empty_buy_money", money, 25);
    check("empty_buy_busy", busy, 0);
    buy = 0; tick();
    load = 4'b0001; tick();
    check("load_stock", dut.stock_q[0], 15);
    check("load_oos_lag", out_of_stock[0], 1);
    load = 4'b0000; tick();
    check("load_oos_clear", out_of_stock[0], 0);
    select = 4'b0001; load = 4'b0001; buy = 1; tick();
    check("load_vs_vend_prod", products, 4'b0001);
    check("load_vs_vend_money", money, 0);
    check("load_vs_vend_stock", dut.stock_q[0], 15);
    buy = 0; load = 4'b0000; tick();

    // Reset in the middle of change payout at money = 50
    do_reset();
    for (int k = 0; k < 4; k++) pulse_quarter();
    refund = 1; tick(); refund = 0;
    tick(); tick(); tick();
    check("midrst_pre_money", money, 50);
    reset = 0; tick();
    check("midrst_money", money, 0);
    check("midrst_coin_out", coin_out, 0);
    check("midrst_led", refundLED, 1);
    check("midrst_busy", busy, 0);
    reset = 1; tick();
    check("midrst_led_after", refundLED, 0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (coin_out) pulses++;
      tick();
    end
    check("midrst_no_coins", 64'(pulses), 0);
    check("midrst_money_after", money, 0);

    // Audit counters: three product-0 vends
    do_reset();
    for (int k = 0; k < 3; k++) pulse_quarter();
    for (int k = 0; k < 3; k++) pulse_buy(4'b0001);
    check("audit_money", money, 0);
`ifdef VEND_AUDIT_EN
    check("audit_slice0", sales_count[15:0], 3);
`else
    check("audit_slice0", sales_count[15:0], 0);
`endif
    check("audit_others", sales_count[63:16], 0);
    load = 4'b0001; tick(); load = 4'b0000; tick();
`ifdef VEND_AUDIT_EN
    check("audit_after_load", sales_count[15:0], 3);
`else
    check("audit_after_load", sales_count[15:0], 0);
`endif
    reset = 0; tick();
    check("audit_after_reset", sales_count, 0);
    reset = 1; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_machine_param.md
VEND_MACHINE_PARAM -- requirements
Module: vend_machine_param

Interface
REQ-001 SHALL have parameter N_PROD, default 4: number of products/channels.
REQ-002 SHALL have parameter STOCK_W, default 4: stock counter width; full stock = 2^STOCK_W-1.
REQ-003 SHALL have parameter MONEY_W, default 12: credit width in cents.
REQ-004 SHALL have parameter MAX_CREDIT, default 995: credit ceiling in cents.
REQ-005 SHALL have parameter PRICES, default {200,150,75,25}: packed N_PROD*MONEY_W vector; product i price = slice i.
REQ-006 SHALL have ports, in order: clk in 1 (single clock, 50 MHz); reset in 1 (synchronous, active-low).
REQ-007 SHALL have ports quarter in 1 (25c coin) and dollar in 1 (100c coin).
REQ-008 SHALL have ports select in N_PROD (one-hot product select), buy in 1, refund in 1, and load in N_PROD (restock request per product).
REQ-009 SHALL have ports money out MONEY_W (current credit) and products out N_PROD (dispense pulse).
REQ-010 SHALL have ports out_of_stock out N_PROD, refundLED out 1 (change being paid), coin_out out 1 (one 25c returned per pulse), coin_reject out 1 (coin not accepted) and busy out 1 (FSM not IDLE).
REQ-011 SHALL have port sales_count out N_PROD*16: per-product sales count (see Configuration).

Function
REQ-012 SHALL act only on rising edges of quarter, dollar, buy and refund, detected against the previous-cycle sample.
REQ-013 SHALL run an FSM with states IDLE, VEND and CHANGE.
REQ-014 In IDLE, a coin edge SHALL add 25 or 100 to money the next cycle if the result is <= MAX_CREDIT; otherwise money SHALL be unchanged and coin_reject SHALL pulse for 1 cycle.
REQ-015 If quarter and dollar edges coincide, the quarter SHALL be processed and the dollar rejected.
REQ-016 In IDLE, a buy edge with select one-hot, money >= price[i] and stock[i] > 0 SHALL, next cycle, assert products[i] for exactly 1 cycle, subtract price[i] from money, decrement stock[i] and enter VEND.
REQ-017 A buy edge with select not one-hot, insufficient credit or zero stock SHALL have no effect.
REQ-018 VEND SHALL last 1 cycle, then return to IDLE.
REQ-019 In IDLE, a refund edge with money >= 25 SHALL enter CHANGE; with money < 25 it SHALL be ignored.
REQ-020 A refund edge coinciding with a buy edge SHALL take priority over buy; coin edges SHALL take priority over both.
REQ-021 In CHANGE, coin_out SHALL pulse every second cycle, each pulse decrementing money by 25; refundLED SHALL be 1 throughout CHANGE.
REQ-022 CHANGE SHALL return to IDLE on the cycle money reaches 0.
REQ-023 Coin edges arriving in VEND or CHANGE SHALL be rejected with a coin_reject pulse; buy and refund edges in those states SHALL be ignored.
REQ-024 load[i] = 1 SHALL set stock[i] to full the next cycle, in any state; if it coincides with a vend of product i, load SHALL win.
REQ-025 out_of_stock[i] SHALL be the registered (stock[i] == 0) flag, updated every cycle with 1-cycle latency.
REQ-026 All arithmetic SHALL be unsigned MONEY_W-bit; money SHALL never wrap.

Reset
REQ-027 On reset = 0 at a clk edge, the block SHALL set money = 0, state = IDLE, all stock = full, and products, out_of_stock, coin_out, coin_reject, busy = 0, with refundLED = 1 for that cycle.
REQ-028 Reset during CHANGE SHALL abandon the remaining change; credit is cleared, not paid.
REQ-029 Reset SHALL also clear the edge-detect history registers and sales_count.

Configuration
REQ-030 With VEND_AUDIT_EN defined, sales_count slice i SHALL increment by 1 on each successful vend of product i, saturating at 16'hFFFF; it is not cleared by load.
REQ-031 Without VEND_AUDIT_EN, sales_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
REQ-032 Package vend_pkg SHALL hold the FSM state enum, coin values (25, 100), the change denomination, and the sales counter width (16).
REQ-033 Rising-edge detection SHALL be a sub-module, edge_detect, instantiated once per quarter, dollar, buy and refund.

Verification
REQ-034 Insert dollar, then buy with select = 0010 (price 75) -> products = 0010 for 1 cycle, money = 25, stock1 = 14.
REQ-035 Insert 10 dollars -> money = 900 after 9 coins; the 10th (1000 > 995) -> coin_reject pulse, money stays 900.
REQ-036 money = 100, pulse refund -> 4 coin_out pulses, 2 cycles apart, refundLED high, money steps 75/50/25/0, then IDLE.
REQ-037 Drain stock0 with 15 buys -> out_of_stock[0] = 1; 16th buy has no effect; load = 0001 -> stock0 = 15, out_of_stock[0] = 0 one cycle later.
REQ-038 Reset low mid-CHANGE at money = 50 -> money = 0, no further coin_out pulses, refundLED = 1 for one cycle.
REQ-039 With VEND_AUDIT_EN defined, 3 gum vends -> sales_count slice 0 = 3; without it, sales_count = 0.
